// File: rtl/aoi_pkg.sv
// rtl/aoi_pkg.sv - shared constants and reference function for the 2-2 AOI cell
package aoi_pkg;

    localparam int CNT_W_DEF = 8;

    // Golden value of ~((a & b) | (c & d)). The dataflow path uses it directly.
    function automatic logic aoi22(input logic a, input logic b, input logic c, input logic d);
        return ~((a & b) | (c & d));
    endfunction

endpackage

// File: rtl/aoi_gates.sv
// rtl/aoi_gates.sv - gate-primitive implementation of the 2-2 AOI cell
module aoi_gates (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic TZ
);

    logic ab;
    logic cd;
    logic ab_or_cd;

    and g_and_ab (ab, A, B);
    and g_and_cd (cd, C, D);
    or  g_or     (ab_or_cd, ab, cd);
    not g_not    (TZ, ab_or_cd);

endmodule

// File: rtl/and_or_invert.sv
// rtl/and_or_invert.sv - self-checking 2-2 AOI cell with registered output and mismatch counter
module and_or_invert
    import aoi_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             TZ,
    output logic             TZ_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic TZ_s;
    logic tz_diff;

    aoi_gates u_gates (
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (D),
        .TZ (TZ_s)
    );

    assign TZ      = aoi22(A, B, C, D);
    assign tz_diff = (TZ_s != TZ);

    // Reset value of TZ_q is what the cell produces for all-zero inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            TZ_q     <= 1'b1;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            TZ_q     <= TZ;
            mismatch <= tz_diff;
            if (tz_diff && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_and_or_invert.sv
// tb/tb_and_or_invert.sv - scoreboard bench for and_or_invert
module tb_and_or_invert;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c, d;
    logic       tz1, tzq1, mm1;
    logic [7:0] cnt1;
    logic       tz2, tzq2, mm2;
    logic [1:0] cnt2;

    bit forced1 = 1'b0;
    bit forced2 = 1'b0;
    int checks  = 0;
    int errors  = 0;

    typedef struct {
        bit q;
        bit m;
        int cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    and_or_invert #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
        .TZ(tz1), .TZ_q(tzq1), .mismatch(mm1), .err_cnt(cnt1)
    );

    and_or_invert #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
        .TZ(tz2), .TZ_q(tzq2), .mismatch(mm2), .err_cnt(cnt2)
    );

    // Output is low exactly when either pair is fully set.
    function automatic bit ref_tz(input logic [3:0] v);
        int p1, p2;
        p1 = int'(v[3]) + int'(v[2]);
        p2 = int'(v[1]) + int'(v[0]);
        return ((p1 == 2) || (p2 == 2)) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected registered state after each edge.
    initial begin
        int m1 = 0, m2 = 0;
        forever begin
            exp_t e1, e2;
            @(posedge clk);
            if (rst) begin
                m1 = 0;
                m2 = 0;
            end else begin
                if (forced1 && m1 < 255) m1 = m1 + 1;
                if (forced2 && m2 < 3)   m2 = m2 + 1;
            end
            e1.q   = rst ? 1'b1 : ref_tz({a, b, c, d});
            e1.m   = rst ? 1'b0 : forced1;
            e1.cnt = m1;
            e2.q   = e1.q;
            e2.m   = rst ? 1'b0 : forced2;
            e2.cnt = m2;
            q1.push_back(e1);
            q2.push_back(e2);
        end
    end

    // Monitor: compare registered outputs on the falling edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("tz_q", int'(tzq1), int'(e.q));
                check("mismatch", int'(mm1), int'(e.m));
                check("err_cnt", int'(cnt1), e.cnt);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("tz_q_w2", int'(tzq2), int'(e.q));
                check("mismatch_w2", int'(mm2), int'(e.m));
                check("err_cnt_w2", int'(cnt2), e.cnt);
            end
        end
    end

    task automatic apply(input logic [3:0] v, input bit f1, input bit f2);
        bit r;
        {a, b, c, d} = v;
        r = ref_tz(v);
        forced1 = f1;
        forced2 = f2;
        if (f1) begin
            if (r) force dut.TZ_s = 1'b0;
            else   force dut.TZ_s = 1'b1;
        end else begin
            release dut.TZ_s;
        end
        if (f2) begin
            if (r) force dut2.TZ_s = 1'b0;
            else   force dut2.TZ_s = 1'b1;
        end else begin
            release dut2.TZ_s;
        end
        #1;
        check("tz_comb", int'(tz1), int'(r));
        check("tz_comb_w2", int'(tz2), int'(r));
        if (!f1) check("tz_s", int'(dut.TZ_s), int'(r));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] walk [9];
        bit         walk_tz [9];
        walk    = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        walk_tz = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        {a, b, c, d} = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tz", int'(tz1), 1);
        check("reset_tz_q", int'(tzq1), 1);
        check("reset_mismatch", int'(mm1), 0);
        check("reset_err_cnt", int'(cnt1), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply(walk[i], 1'b0, 1'b0);
            check("walk_tz", int'(tz1), int'(walk_tz[i]));
            #4;
        end

        next_cycle();
        for (int i = 0; i < 16; i++) begin
            apply(4'(i), 1'b0, 1'b0);
            next_cycle();
        end

        for (int k = 0; k < 3; k++) begin
            apply(4'b1010, 1'b1, 1'b0);
            next_cycle();
            check("forced_mismatch", int'(mm1), 1);
        end
        check("forced_err_cnt", int'(cnt1), 3);
        apply(4'b1010, 1'b0, 1'b0);
        next_cycle();
        check("released_mismatch", int'(mm1), 0);
        check("released_err_cnt_hold", int'(cnt1), 3);

        for (int k = 0; k < 6; k++) begin
            apply(4'b0101, 1'b0, 1'b1);
            next_cycle();
        end
        check("sat_err_cnt_w2", int'(cnt2), 3);
        rst = 1'b1;
        next_cycle();
        check("rst_wins_err_cnt_w2", int'(cnt2), 0);
        check("rst_tz_q_w2", int'(tzq2), 1);
        rst = 1'b0;
        apply(4'b0000, 1'b0, 1'b0);
        next_cycle();

        rst = 1'b1;
        apply(4'b1100, 1'b0, 1'b0);
        check("rst_tz_comb", int'(tz1), 0);
        next_cycle();
        check("rst_tz_q", int'(tzq1), 1);
        rst = 1'b0;
        next_cycle();
        check("post_rst_tz_q", int'(tzq1), 0);

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            apply(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            next_cycle();
        end

        rst = 1'b0;
        apply(4'b0000, 1'b0, 1'b0);
        repeat (3) next_cycle();
        @(negedge clk);
        #1;
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
